// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the event inputs, the ICache bank side and the
// instruction-queue handshake of the F-stage fetch controller.
//   master : the fetch controller (drives bank OE, line addresses, valid)
//   slave  : the environment (events, bank miss flags, queue ready)
// Signals:
//   is_init/init_addr, is_resteer/resteer_addr : fetch start / redirect
//   cache_miss_even/odd : bank miss flags, valid the cycle after OE
//   line_ready          : queue accepts the current pair
//   even_OE/odd_OE      : bank read enables
//   FIP_e/FIP_o         : even/odd bank line addresses
//   fetch_offset        : byte offset of first valid byte in the pair
//   line_valid          : pair on the bank outputs is good
//   ptr_wrap            : pulse when the line pointer wraps
interface fetch_ctrl_if #(
    parameter int ADDR_W = 28
);
    logic              is_init;
    logic [31:0]       init_addr;
    logic              is_resteer;
    logic [31:0]       resteer_addr;
    logic              cache_miss_even;
    logic              cache_miss_odd;
    logic              line_ready;
    logic              even_OE;
    logic              odd_OE;
    logic [ADDR_W-1:0] FIP_e;
    logic [ADDR_W-1:0] FIP_o;
    logic [3:0]        fetch_offset;
    logic              line_valid;
    logic              ptr_wrap;

    modport master (
        input  is_init, init_addr, is_resteer, resteer_addr,
        input  cache_miss_even, cache_miss_odd, line_ready,
        output even_OE, odd_OE, FIP_e, FIP_o, fetch_offset, line_valid, ptr_wrap
    );

    modport slave (
        output is_init, init_addr, is_resteer, resteer_addr,
        output cache_miss_even, cache_miss_odd, line_ready,
        input  even_OE, odd_OE, FIP_e, FIP_o, fetch_offset, line_valid, ptr_wrap
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: F-stage fetch sequencer. Converts init/resteer events into
// even/odd ICache line-pair requests, waits out misses and replays them, and
// hands each good pair to the instruction queue with a valid/ready handshake.
// Ports:
//   clk  : clock, posedge
//   clr  : asynchronous active-low reset
//   bus  : fetch_ctrl_if.master (events, bank control, queue handshake)
// Parameters:
//   MISS_LAT : cycles spent in MISS before the request is replayed (>=1)
//   ADDR_W   : line-address width (byte address bits [ADDR_W+3:4])
module fetch_ctrl #(
    parameter int MISS_LAT = 4,
    parameter int ADDR_W   = 28
) (
    input  logic         clk,
    input  logic         clr,
    fetch_ctrl_if.master bus
);
    localparam int CW = $clog2(MISS_LAT + 1);

    typedef enum logic [2:0] {IDLE, REQ, RESP, MISS, VALID} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [3:0]        offset;
    logic [CW-1:0]     cnt;
    logic              oe;
    logic              valid;
    logic              wrap;

    logic              event_hit;
    logic [31:0]       event_addr;
    logic [ADDR_W:0]   ptr_inc;

    // init outranks resteer when both fire together
    assign event_hit  = bus.is_init | bus.is_resteer;
    assign event_addr = bus.is_init ? bus.init_addr : bus.resteer_addr;
    // extra MSB catches the carry out of the top line-address bit
    assign ptr_inc    = {1'b0, ptr} + (ADDR_W+1)'(2);

    // The first line of the pair goes to whichever bank matches its parity;
    // the other bank gets the following line (modulo 2^ADDR_W).
    assign bus.FIP_e        = ptr[0] ? ptr + ADDR_W'(1) : ptr;
    assign bus.FIP_o        = ptr[0] ? ptr : ptr + ADDR_W'(1);
    assign bus.fetch_offset = offset;
    assign bus.even_OE      = oe;
    assign bus.odd_OE       = oe;
    assign bus.line_valid   = valid;
    assign bus.ptr_wrap     = wrap;

    // Outputs are registered alongside the state so they line up with it.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= IDLE;
            ptr    <= '0;
            offset <= '0;
            cnt    <= '0;
            oe     <= 1'b0;
            valid  <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (event_hit) begin
                // Any in-flight pair is dropped; a concurrent handshake in
                // VALID still completes but the pointer follows the event.
                ptr    <= event_addr[4 +: ADDR_W];
                offset <= event_addr[3:0];
                cnt    <= '0;
                state  <= REQ;
                oe     <= 1'b1;
                valid  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        oe    <= 1'b0;
                        valid <= 1'b0;
                    end
                    REQ: begin
                        state <= RESP;
                        oe    <= 1'b0;
                    end
                    RESP: begin
                        if (bus.cache_miss_even || bus.cache_miss_odd) begin
                            state <= MISS;
                            cnt   <= CW'(MISS_LAT - 1);
                        end else begin
                            state <= VALID;
                            valid <= 1'b1;
                        end
                    end
                    MISS: begin
                        if (cnt == '0) begin
                            // replay both banks with the unchanged pointer
                            state <= REQ;
                            oe    <= 1'b1;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    VALID: begin
                        if (bus.line_ready) begin
                            ptr    <= ptr_inc[ADDR_W-1:0];
                            wrap   <= ptr_inc[ADDR_W];
                            offset <= '0;
                            state  <= REQ;
                            oe     <= 1'b1;
                            valid  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        oe    <= 1'b0;
                        valid <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the even/odd ICache banks and the fetch instruction pointer (FIP) for the F stage.
- Turns init/resteer events into line-pair requests.
- Drives bank OE and the FIP_e/FIP_o line addresses, waits out cache misses and replays the request.
- Presents each good line pair to the instruction queue with a valid/ready handshake.

Parameters:
MISS_LAT, 4, cycles spent in MISS before the request is replayed (>=1)
ADDR_W, 28, line-address width (byte address bits [31:4])

Ports:
clk  in  1  clock, posedge
clr  in  1  asynchronous active-low reset
is_init  in  1  load init_addr and start fetching
init_addr  in  32  byte start address
is_resteer  in  1  redirect fetch to resteer_addr
resteer_addr  in  32  byte redirect address
cache_miss_even  in  1  even bank miss, valid the cycle after even_OE
cache_miss_odd  in  1  odd bank miss, valid the cycle after odd_OE
line_ready  in  1  queue accepts the current pair
even_OE  out  1  even bank read enable
odd_OE  out  1  odd bank read enable
FIP_e  out  28  even-bank line address
FIP_o  out  28  odd-bank line address
fetch_offset  out  4  byte offset of first valid byte in the pair
line_valid  out  1  pair on the bank outputs is good
ptr_wrap  out  1  one-cycle pulse when ptr wraps past 2^28-1

Behaviour:
- Internal state:
  - ptr[27:0]: line address of the first line of the pair.
  - FSM: IDLE, REQ, RESP, MISS, VALID.
  - miss counter: width clog2(MISS_LAT+1).
- Reset (clr=0, async): state=IDLE, ptr=0, fetch_offset=0, counter=0. Outputs: OE=0, line_valid=0, ptr_wrap=0.
- Line addressing (combinational from ptr):
  - ptr[0]=0: FIP_e=ptr, FIP_o=ptr+1.
  - ptr[0]=1: FIP_o=ptr, FIP_e=ptr+1 (mod 2^28).
  - FIP_e/FIP_o hold stable from REQ through VALID.
- even_OE=odd_OE=1 only in REQ; 0 in every other state.
- IDLE: stays until is_init or is_resteer.
- REQ: OE asserted; next state RESP unconditionally (banks register data and miss flags).
- RESP: samples the miss flags.
  - Either flag=1: go to MISS, counter=MISS_LAT-1.
  - Both flags=0: go to VALID.
- MISS: counter decrements each cycle. At counter==0, go to REQ with the same ptr; both banks are replayed.
- VALID: line_valid=1.
  - line_ready=1: ptr<=ptr+2, fetch_offset<=0, go to REQ.
  - line_ready=0: hold in VALID; ptr and FIP stay unchanged.
- Throughput: one pair per 3 cycles with no misses and ready held high. Handshake: REQ, RESP, VALID.
- Wrap:
  - ptr+2 is computed modulo 2^28; bits [31:28] of addresses are dropped.
  - ptr_wrap pulses for one cycle when the increment carries out of bit 27.
- Event priority, evaluated every cycle in any state:
  - is_init > is_resteer > normal FSM step.
  - On either event: ptr<=addr[31:4], fetch_offset<=addr[3:0], counter<=0, next state REQ.
  - Any in-flight RESP/MISS/VALID pair is discarded; line_valid drops the following cycle.
  - If the event coincides with a line_ready handshake in VALID, the handshake still completes that cycle, but ptr takes the event address, not ptr+2.
- Miss flags arriving in states other than RESP are ignored.
- is_init and is_resteer held high for several cycles keep re-entering REQ. The FSM only progresses once the event is deasserted.
- Reset asserted mid-operation returns to IDLE immediately; no pair is emitted.

Test Plan:
1. Reset: assert clr=0 mid-VALID. Required: line_valid=0, OE=0, FIP_e=0, FIP_o=1, state IDLE; nothing emitted until is_init.
2. Even start: is_init with init_addr=0x0000_1004, no misses, line_ready=1.
   - REQ cycle: FIP_e=0x100, FIP_o=0x101, offset=4, both OE=1.
   - line_valid=1 two cycles later.
   - Next REQ: FIP_e=0x102, FIP_o=0x103, offset=0.
3. Odd start: init_addr=0x0000_1010. Required: FIP_o=0x101, FIP_e=0x102; after accept, FIP_o=0x103, FIP_e=0x104.
4. Miss: MISS_LAT=4, cache_miss_odd=1 in RESP. Required: exactly 4 MISS cycles, OE=0 and line_valid=0 throughout, then REQ replays the same FIP_e/FIP_o.
5. Resteer: is_resteer during MISS with resteer_addr=0x0000_2008.
   - Next cycle: REQ with FIP_e=0x200, FIP_o=0x201, offset=8.
   - The old pair is never presented.
   - Simultaneous is_init=0x0000_3000 wins: FIP_e=0x300.
6. Backpressure and wrap: line_ready=0 for 5 cycles in VALID, then ptr=0xFFFFFFF accepted.
   - During stall: line_valid and FIP stay stable.
   - On accept: ptr becomes 0x0000001 and ptr_wrap pulses exactly one cycle.
